roi_frame_reader: RTL and testbench

- Downstream consumer of the dual-port frame RAM (180x150 pixels, 8-bit, row-major, addr = row*180 + col).
- On a start pulse, reads a rectangular region of interest through one RAM read port and streams the pixels out on a valid/ready interface.
- The stream carries start-of-line, end-of-line and end-of-frame markers, and feeds the eye-tracking processing stages.

---
 rtl/roi_frame_reader.sv | 177 +++++++++++++++++
 tb/tb_roi_frame_reader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/roi_frame_reader.sv
// Reads a rectangular region of the frame RAM in raster order and streams it
// out on a valid/ready pixel interface with line and frame markers.
module roi_frame_reader #(
    parameter int IMG_W   = 180,
    parameter int IMG_H   = 150,
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 8,
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COORD_W-1:0] roi_x0,
    input  logic [COORD_W-1:0] roi_y0,
    input  logic [COORD_W-1:0] roi_w,
    input  logic [COORD_W-1:0] roi_h,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_w_en,
    input  logic [DATA_W-1:0]  ram_rd_data,
    output logic [DATA_W-1:0]  pix_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               pix_sol,
    output logic               pix_eol,
    output logic               pix_eof,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int SUM_W = COORD_W + 1;
    localparam int ENT_W = DATA_W + 3;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t             state_reg;
    logic [COORD_W-1:0] w_reg, h_reg, col_reg, row_reg;
    logic [ADDR_W-1:0]  row_base_reg, ram_addr_reg;
    logic               prime_reg;
    logic               fl_valid_reg, fl_sol_reg, fl_eol_reg, fl_eof_reg;
    logic               busy_reg, done_reg, err_reg;

    logic [ENT_W-1:0]   fifo_mem [2];
    logic               wr_ptr_reg, rd_ptr_reg;
    logic [1:0]         count_reg;

    logic               roi_bad, last_col, last_row, pop, push, issue;
    logic [2:0]         pending;
    logic [ADDR_W-1:0]  start_base;
    logic [ENT_W-1:0]   head;

    always_comb begin
        roi_bad = (roi_w == '0) || (roi_h == '0)
               || (({1'b0, roi_x0} + {1'b0, roi_w}) > SUM_W'(IMG_W))
               || (({1'b0, roi_y0} + {1'b0, roi_h}) > SUM_W'(IMG_H));
        start_base = ADDR_W'(roi_y0) * ADDR_W'(IMG_W) + ADDR_W'(roi_x0);
        last_col   = (col_reg == w_reg - COORD_W'(1));
        last_row   = (row_reg == h_reg - COORD_W'(1));
        pop        = (count_reg != 2'd0) && pix_ready;
        push       = fl_valid_reg;
        // Reads in flight and queued pixels together never exceed the FIFO depth.
        pending    = 3'(count_reg) + 3'(fl_valid_reg);
        issue      = (state_reg == READ) && !prime_reg && (pending < 3'd2 + 3'(pop));
        head       = fifo_mem[rd_ptr_reg];
    end

    assign ram_addr  = ram_addr_reg;
    assign ram_w_en  = 1'b0;
    assign pix_valid = (count_reg != 2'd0);
    assign pix_data  = head[DATA_W-1:0];
    assign pix_sol   = pix_valid & head[DATA_W];
    assign pix_eol   = pix_valid & head[DATA_W+1];
    assign pix_eof   = pix_valid & head[DATA_W+2];
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_reg] <= {fl_eof_reg, fl_eol_reg, fl_sol_reg, ram_rd_data};
                wr_ptr_reg           <= ~wr_ptr_reg;
            end
            if (pop) rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            w_reg        <= '0;
            h_reg        <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            row_base_reg <= '0;
            ram_addr_reg <= '0;
            prime_reg    <= 1'b0;
            fl_valid_reg <= 1'b0;
            fl_sol_reg   <= 1'b0;
            fl_eol_reg   <= 1'b0;
            fl_eof_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            fl_valid_reg <= issue;
            if (issue) begin
                fl_sol_reg <= (col_reg == '0);
                fl_eol_reg <= last_col;
                fl_eof_reg <= last_col && last_row;
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        w_reg        <= roi_w;
                        h_reg        <= roi_h;
                        col_reg      <= '0;
                        row_reg      <= '0;
                        row_base_reg <= start_base;
                        if (roi_bad) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                        end else begin
                            state_reg <= READ;
                            busy_reg  <= 1'b1;
                            prime_reg <= 1'b1;
                        end
                    end
                end
                READ: begin
                    // First READ cycle only presents the ROI origin address.
                    if (prime_reg) begin
                        ram_addr_reg <= row_base_reg;
                        prime_reg    <= 1'b0;
                    end else if (issue) begin
                        if (last_col) begin
                            col_reg <= '0;
                            if (last_row) begin
                                state_reg <= DRAIN;
                            end else begin
                                row_reg      <= row_reg + COORD_W'(1);
                                row_base_reg <= row_base_reg + ADDR_W'(IMG_W);
                                ram_addr_reg <= row_base_reg + ADDR_W'(IMG_W);
                            end
                        end else begin
                            col_reg      <= col_reg + COORD_W'(1);
                            ram_addr_reg <= row_base_reg + ADDR_W'(col_reg) + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!fl_valid_reg && (count_reg == 2'd0 || (count_reg == 2'd1 && pop))) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_roi_frame_reader.sv
// Directed bench for roi_frame_reader: behavioural frame RAM, expected-pixel
// queue built from the ROI geometry, and one per-cycle compare process.
`timescale 1ns/1ps
module tb_roi_frame_reader;
    localparam int IMG_W = 180, IMG_H = 150, ADDR_W = 17, DATA_W = 8, COORD_W = 8;
    localparam int NPIX = IMG_W * IMG_H;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               start = 1'b0;
    logic [COORD_W-1:0] roi_x0 = '0, roi_y0 = '0, roi_w = '0, roi_h = '0;
    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_w_en;
    logic [DATA_W-1:0]  ram_rd_data = '0;
    logic [DATA_W-1:0]  pix_data;
    logic               pix_valid, pix_ready = 1'b1;
    logic               pix_sol, pix_eol, pix_eof, busy, done, err;

    roi_frame_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
                       .DATA_W(DATA_W), .COORD_W(COORD_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .roi_x0(roi_x0), .roi_y0(roi_y0), .roi_w(roi_w), .roi_h(roi_h),
        .ram_addr(ram_addr), .ram_w_en(ram_w_en), .ram_rd_data(ram_rd_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_eof(pix_eof),
        .busy(busy), .done(done), .err(err));

    always #5 clk = ~clk;

    function automatic logic [7:0] dval(input int a);
        return 8'((a * 37) ^ (a >> 7));
    endfunction

    logic [7:0] ram [NPIX];
    always @(posedge clk)
        ram_rd_data <= (int'(ram_addr) < NPIX) ? ram[int'(ram_addr)] : 8'h00;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int first_valid_cyc = -1, eof_cyc = -1, done_cyc = -1;
    int n_done = 0, n_sol = 0, n_eol = 0;
    int start_ncyc = 0, model_first = 0, model_last = 0, n_exp = 0;
    bit exp_err = 1'b0;
    logic [10:0] exp_q[$];
    bit prev_stall = 1'b0;
    logic [11:0] prev_vec = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected stream: raster order over the ROI, addr = row*IMG_W + col.
    task automatic build_model(input int x0, input int y0, input int w, input int h);
        int a;
        exp_q.delete();
        n_exp   = 0;
        exp_err = (w == 0) || (h == 0) || (x0 + w > IMG_W) || (y0 + h > IMG_H);
        if (!exp_err) begin
            for (int r = 0; r < h; r++) begin
                for (int c = 0; c < w; c++) begin
                    a = (y0 + r) * IMG_W + x0 + c;
                    exp_q.push_back({dval(a), c == 0, c == w - 1, (c == w - 1) && (r == h - 1)});
                    if (n_exp == 0) model_first = a;
                    model_last = a;
                    n_exp++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        logic [10:0] e;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {pix_valid, pix_data, pix_sol, pix_eol, pix_eof}, prev_vec);
            if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", pix_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", {pix_data, pix_sol, pix_eol, pix_eof}, e);
                    if (pix_sol) n_sol++;
                    if (pix_eol) n_eol++;
                    if (pix_eof) eof_cyc = cyc;
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                check("done_err", err, exp_err);
                check("done_busy", busy, 1'b0);
                if (!exp_err) begin
                    check("done_after_eof", cyc, eof_cyc + 1);
                    check("done_queue_empty", exp_q.size(), 0);
                end
            end
            prev_stall = pix_valid && !pix_ready;
            prev_vec   = {pix_valid, pix_data, pix_sol, pix_eol, pix_eof};
        end
    end

    task automatic run_roi(input int x0, input int y0, input int w, input int h,
                           input bit rnd, input bit inject);
        int base_done, sol0, eol0, k;
        build_model(x0, y0, w, h);
        first_valid_cyc = -1; eof_cyc = -1; done_cyc = -1;
        base_done = n_done; sol0 = n_sol; eol0 = n_eol;
        roi_x0 = 8'(x0); roi_y0 = 8'(y0); roi_w = 8'(w); roi_h = 8'(h);
        start = 1'b1;
        start_ncyc = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        roi_x0 = 8'($urandom); roi_y0 = 8'($urandom); roi_w = 8'($urandom); roi_h = 8'($urandom);
        k = 0;
        while (n_done == base_done && k < 40000) begin
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inject) begin
                start = (k == 4);
                roi_x0 = 8'd179; roi_y0 = 8'd149; roi_w = 8'd1; roi_h = 8'd1;
            end
            if (exp_err) check("err_busy", busy, 1'b0);
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        pix_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("done_count", n_done - base_done, 1);
        if (exp_err) begin
            check("err_done_latency", done_cyc - start_ncyc, 1);
            check("err_no_pixel", first_valid_cyc, -1);
        end else begin
            // start_ncyc+1 is the first cycle after the edge that sampled start
            check("first_valid_latency", first_valid_cyc - (start_ncyc + 1), 3);
            check("all_pixels_seen", exp_q.size(), 0);
            check("sol_count", n_sol - sol0, h);
            check("eol_count", n_eol - eol0, h);
            check("addr_hold_last", ram_addr, model_last);
            if (!rnd) check("no_bubbles", eof_cyc - first_valid_cyc, n_exp - 1);
        end
        $display("roi x0=%0d y0=%0d w=%0d h=%0d ready=%s err=%0d pixels=%0d done_cycle=%0d",
                 x0, y0, w, h, rnd ? "random" : "high", exp_err, n_exp, done_cyc);
    endtask

    initial begin
        int base_done;
        for (int a = 0; a < NPIX; a++) ram[a] = dval(a);
        #1 rst_n = 1'b0;
        #1;
        check("reset_outputs", {ram_addr, pix_data, pix_valid, pix_sol, pix_eol, pix_eof,
                                busy, done, err}, 32'd0);
        check("ram_w_en", ram_w_en, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        build_model(10, 20, 4, 3);
        check("model_first_addr", model_first, 3610);
        check("model_last_addr", model_last, 3973);
        check("model_row1_sol", exp_q[4][2], 1'b1);
        check("model_row0_eol", exp_q[3][1], 1'b1);
        check("model_eof", exp_q[11][0], 1'b1);
        run_roi(10, 20, 4, 3, 1'b0, 1'b0);
        run_roi(10, 20, 4, 3, 1'b1, 1'b0);
        run_roi(178, 0, 4, 1, 1'b0, 1'b0);
        run_roi(10, 20, 0, 3, 1'b0, 1'b0);

        build_model(179, 149, 1, 1);
        check("model_corner_addr", model_first, 26999);
        check("model_corner_markers", exp_q[0][2:0], 3'b111);
        run_roi(179, 149, 1, 1, 1'b0, 1'b0);
        run_roi(5, 7, 1, 3, 1'b1, 1'b0);
        run_roi(10, 20, 4, 3, 1'b0, 1'b1);

        build_model(0, 0, IMG_W, IMG_H);
        check("model_full_count", n_exp, 27000);
        check("model_full_last", model_last, 26999);
        run_roi(0, 0, IMG_W, IMG_H, 1'b0, 1'b0);

        // Abort a full-frame transfer with reset.
        build_model(0, 0, IMG_W, IMG_H);
        base_done = n_done;
        roi_x0 = 8'd0; roi_y0 = 8'd0; roi_w = 8'd180; roi_h = 8'd150;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_outputs", {ram_addr, pix_data, pix_valid, pix_sol, pix_eol, pix_eof,
                                busy, done, err}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", n_done - base_done, 0);
        $display("reset abort of full frame, done pulses=%0d", n_done - base_done);
        run_roi(10, 20, 4, 3, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
